// File: rtl/phv_pkg.sv
// Shared constants and types for the packet parser front end.
// Provides PHV geometry, metadata field positions, parser FSM state
// encodings, the metadata payload struct and a saturating length adder.
package phv_pkg;

    localparam int unsigned DATA_W        = 256;
    localparam int unsigned TUSER_W       = 128;
    localparam int unsigned HDR_LEN       = 1024;
    localparam int unsigned PHV_LEN       = 1579;
    localparam int unsigned META_LEN      = 256;
    localparam int unsigned META_LEN_LSB  = 0;
    localparam int unsigned META_PORT_LSB = 16;
    localparam int unsigned LEN_W         = 16;
    localparam int unsigned PORT_W        = 8;
    localparam int unsigned TUSER_PORT_LSB = 16;

    // Parser FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] BODY = 2'd2;

    // Metadata payload placed in the low bits of the PHV (len at bit 0, port at META_PORT_LSB)
    typedef struct packed {
        logic [PORT_W-1:0] src_port;
        logic [LEN_W-1:0]  len;
    } phv_meta_t;

    // Byte-count accumulation that sticks at all-ones instead of wrapping
    function automatic logic [LEN_W-1:0] len_sat_add(input logic [LEN_W-1:0] a,
                                                     input logic [LEN_W-1:0] b);
        logic [LEN_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/keep_popcount.sv
// Counts set bits of an AXI-Stream tkeep vector (bytes present in a beat).
// Ports: keep - byte enables; count - number of enabled bytes.
// Purely combinational; shared with the deparser.
module keep_popcount #(
    parameter int unsigned KEEP_W = 32,
    localparam int unsigned CNT_W = $clog2(KEEP_W + 1)
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [CNT_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            count = count + CNT_W'(keep[i]);
        end
    end

endmodule

// File: rtl/phv_parser.sv
// Packet parser: captures the first HDR_LEN bits of each AXI-Stream packet
// into a header window and emits a PHV (window + src port + byte length)
// as a one-cycle strobe the cycle after the packet's last beat.
// Ports:
//   axis_clk, aresetn          - clock, async active-low reset
//   s_axis_tdata/tkeep/tuser   - beat payload, byte enables, sideband (port in [23:16])
//   s_axis_tvalid/tlast        - beat valid, last beat of packet
//   s_axis_tready              - registered accept, high from first edge after reset
//   phv_out, phv_out_valid     - PHV to stage 0 and its one-cycle strobe
module phv_parser #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = phv_pkg::DATA_W,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = phv_pkg::TUSER_W,
    parameter int unsigned HDR_LEN              = phv_pkg::HDR_LEN,
    parameter int unsigned PHV_LEN              = phv_pkg::PHV_LEN,
    parameter int unsigned META_LEN             = phv_pkg::META_LEN
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_out_valid
);
    import phv_pkg::*;

    localparam int unsigned DW     = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned KW     = DW / 8;
    localparam int unsigned NBEATS = HDR_LEN / DW;
    localparam int unsigned BCNT_W = $clog2(NBEATS + 1);
    localparam int unsigned CNT_W  = $clog2(KW + 1);

    logic [1:0]          state, state_nxt;
    logic [BCNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic [LEN_W-1:0]    len, len_nxt;
    logic [PORT_W-1:0]   src_port, src_port_nxt;
    logic [HDR_LEN-1:0]  window, window_nxt;
    logic [PHV_LEN-1:0]  phv_out_nxt;
    logic                phv_out_valid_nxt;
    logic                accept_c;
    logic                emit_c;
    logic [CNT_W-1:0]    beat_bytes_c;
    logic [DW-1:0]       beat_swapped_c;
    phv_meta_t           meta_c;
    logic                unused_tuser_c;

    assign accept_c       = s_axis_tvalid & s_axis_tready;
    assign unused_tuser_c = ^{s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:TUSER_PORT_LSB+PORT_W],
                              s_axis_tuser[TUSER_PORT_LSB-1:0]};

    keep_popcount #(.KEEP_W(KW)) u_keep_popcount (
        .keep  (s_axis_tkeep),
        .count (beat_bytes_c)
    );

    // Byte-swap the beat so packet byte 0 lands at the MSB; absent bytes read as zero
    always_comb begin
        beat_swapped_c = '0;
        for (int i = 0; i < KW; i++) begin
            beat_swapped_c[DW-1-8*i -: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
        end
    end

    // Next-state, datapath and PHV assembly
    always_comb begin
        state_nxt         = state;
        beat_cnt_nxt      = beat_cnt;
        len_nxt           = len;
        src_port_nxt      = src_port;
        window_nxt        = window;
        phv_out_nxt       = phv_out;
        phv_out_valid_nxt = 1'b0;
        emit_c            = 1'b0;
        meta_c            = '0;

        if (accept_c) begin
            case (state)
                IDLE: begin
                    window_nxt                   = '0;
                    window_nxt[HDR_LEN-1 -: DW]  = beat_swapped_c;
                    src_port_nxt                 = s_axis_tuser[TUSER_PORT_LSB +: PORT_W];
                    len_nxt                      = LEN_W'(beat_bytes_c);
                    beat_cnt_nxt                 = BCNT_W'(1);
                    if (s_axis_tlast) begin
                        emit_c = 1'b1;
                    end else begin
                        state_nxt = (NBEATS > 1) ? HDR : BODY;
                    end
                end
                HDR: begin
                    // Constant-index slots keep the write a simple mux per window slice
                    for (int k = 1; k < NBEATS; k++) begin
                        if (beat_cnt == BCNT_W'(k)) begin
                            window_nxt[HDR_LEN-1-k*DW -: DW] = beat_swapped_c;
                        end
                    end
                    len_nxt      = len_sat_add(len, LEN_W'(beat_bytes_c));
                    beat_cnt_nxt = beat_cnt + BCNT_W'(1);
                    if (s_axis_tlast) begin
                        emit_c    = 1'b1;
                        state_nxt = IDLE;
                    end else if (beat_cnt == BCNT_W'(NBEATS - 1)) begin
                        state_nxt = BODY;
                    end
                end
                BODY: begin
                    len_nxt = len_sat_add(len, LEN_W'(beat_bytes_c));
                    if (s_axis_tlast) begin
                        emit_c    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (emit_c) begin
            beat_cnt_nxt                           = '0;
            meta_c.src_port                        = src_port_nxt;
            meta_c.len                             = len_nxt;
            phv_out_nxt                            = '0;
            phv_out_nxt[PHV_LEN-1 -: HDR_LEN]      = window_nxt;
            phv_out_nxt[META_LEN_LSB +: META_LEN]  = META_LEN'(meta_c);
            phv_out_valid_nxt                      = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            len           <= '0;
            src_port      <= '0;
            window        <= '0;
            s_axis_tready <= 1'b0;
            phv_out       <= '0;
            phv_out_valid <= 1'b0;
        end else begin
            state         <= state_nxt;
            beat_cnt      <= beat_cnt_nxt;
            len           <= len_nxt;
            src_port      <= src_port_nxt;
            window        <= window_nxt;
            s_axis_tready <= 1'b1;
            phv_out       <= phv_out_nxt;
            phv_out_valid <= phv_out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_phv_parser.sv
// Directed bench for phv_parser: hand-computed PHV windows and metadata.
module tb_phv_parser;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;
    localparam int HL = 1024;
    localparam int PL = 1579;
    localparam int ML = 256;

    logic            axis_clk = 1'b0;
    logic            aresetn  = 1'b0;
    logic [DW-1:0]   s_axis_tdata  = '0;
    logic [KW-1:0]   s_axis_tkeep  = '0;
    logic [UW-1:0]   s_axis_tuser  = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tlast  = 1'b0;
    logic            s_axis_tready;
    logic [PL-1:0]   phv_out;
    logic            phv_out_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int strobes = 0;

    phv_parser dut (
        .axis_clk      (axis_clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .phv_out       (phv_out),
        .phv_out_valid (phv_out_valid)
    );

    always #5 axis_clk = ~axis_clk;

    always @(negedge axis_clk) begin
        if (phv_out_valid) strobes = strobes + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe, four window slices, the gap between window and metadata, and the metadata
    task automatic check_phv(input string tag, input logic [HL-1:0] win,
                             input logic [7:0] port, input logic [15:0] len);
        logic [PL-HL-ML-1:0] mid;
        check($sformatf("%s_vld", tag), 256'(phv_out_valid), 256'd1);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_win%0d", tag, c), phv_out[PL-1-256*c -: 256], win[HL-1-256*c -: 256]);
        end
        mid = phv_out[PL-HL-1:ML];
        check($sformatf("%s_mid", tag), 256'(|mid), 256'd0);
        check($sformatf("%s_meta", tag), phv_out[ML-1:0], {232'd0, port, len});
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic [7:0] port, input logic last);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = '0;
        s_axis_tuser[23:16] = port;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        @(posedge axis_clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) begin
            @(posedge axis_clk);
            #1;
        end
    endtask

    task automatic send_gap_pkt(input int gap);
        logic [DW-1:0] d1;
        d1 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
        send({32{8'hC0}}, '1, 8'h07, 1'b0);
        idle(gap);
        send(d1, 32'hFFFF_FFF0, 8'h07, 1'b0);
        idle(gap);
        send({32{8'hC2}}, '1, 8'h07, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] d1;
        logic [HL-1:0] gap_win;
        int s0;
        d1 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
        gap_win = {{32{8'hC0}},
                   256'h000000000405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   {32{8'hC2}}, 256'd0};

        // Reset state
        repeat (2) @(posedge axis_clk);
        #1;
        check("rst_tready", 256'(s_axis_tready), 256'd0);
        check("rst_valid", 256'(phv_out_valid), 256'd0);
        check("rst_phv", 256'(|phv_out), 256'd0);
        aresetn = 1'b1;
        idle(1);
        check("tready_up", 256'(s_axis_tready), 256'd1);

        // Single-beat packet, full keep
        send(d1, '1, 8'h03, 1'b1);
        check_phv("one",
                  {256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 768'd0},
                  8'h03, 16'd32);
        idle(1);
        check("one_pulse", 256'(phv_out_valid), 256'd0);
        check("one_hold", phv_out[ML-1:0], {232'd0, 8'h03, 16'd32});

        // Six beats, partial last beat; later tuser values must be ignored
        for (int b = 0; b < 6; b++) begin
            logic [7:0] bv;
            bv = 8'h10 + 8'(b);
            send({32{bv}}, (b == 5) ? 32'h0000_FFFF : 32'hFFFF_FFFF,
                 (b == 0) ? 8'h05 : 8'hEE, (b == 5));
            if (b == 4) check("six_novld", 256'(phv_out_valid), 256'd0);
        end
        check_phv("six", {{32{8'h10}}, {32{8'h11}}, {32{8'h12}}, {32{8'h13}}}, 8'h05, 16'd176);

        // Back-to-back two-beat packets
        idle(2);
        send({32{8'hA0}}, '1, 8'h01, 1'b0);
        send({32{8'hA1}}, '1, 8'h01, 1'b1);
        check_phv("pa", {{32{8'hA0}}, {32{8'hA1}}, 512'd0}, 8'h01, 16'd64);
        send({32{8'hB0}}, '1, 8'h02, 1'b0);
        check("pa_pulse", 256'(phv_out_valid), 256'd0);
        check("pa_hold", phv_out[ML-1:0], {232'd0, 8'h01, 16'd64});
        send({32{8'hB1}}, 32'h0000_000F, 8'h02, 1'b1);
        check_phv("pb", {{32{8'hB0}}, 32'hB1B1B1B1, 224'd0, 512'd0}, 8'h02, 16'd36);
        idle(1);

        // Same packet with and without tvalid gaps
        send_gap_pkt(0);
        check_phv("nogap", gap_win, 8'h07, 16'd92);
        idle(2);
        send_gap_pkt(3);
        check_phv("gap", gap_win, 8'h07, 16'd92);
        idle(1);

        // Reset during beat 2 of 4, then a one-beat packet
        s0 = strobes;
        send({32{8'hD0}}, '1, 8'h09, 1'b0);
        send({32{8'hD1}}, '1, 8'h09, 1'b0);
        s_axis_tdata = {32{8'hD2}};
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_tready", 256'(s_axis_tready), 256'd0);
        check("mid_rst_valid", 256'(phv_out_valid), 256'd0);
        check("mid_rst_phv", 256'(|phv_out), 256'd0);
        s_axis_tvalid = 1'b0;
        idle(2);
        aresetn = 1'b1;
        idle(1);
        send({32{8'h5A}}, 32'h0000_00FF, 8'h0B, 1'b1);
        check_phv("post_rst", {64'h5a5a5a5a5a5a5a5a, 960'd0}, 8'h0B, 16'd8);
        idle(2);
        check("post_rst_strobes", 256'(strobes - s0), 256'd1);

        // Length saturation over 2100 full beats
        for (int i = 0; i < 2100; i++) begin
            send('0, '1, 8'h44, (i == 2099));
        end
        check_phv("sat", '0, 8'h44, 16'hFFFF);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phv_parser.md
Name: phv_parser

Overview:
- Front end of the match-action pipeline; sits directly upstream of stage 0 and drives its phv_in/phv_in_valid.
- Consumes packets from an AXI4-Stream slave and captures the first HDR_LEN bits of each packet as the header window.
- Builds a PHV from the header window plus packet metadata and emits it as a one-cycle valid pulse after the packet's last beat.
- No downstream backpressure: stage accepts a PHV every cycle.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, stream data width in bits; HDR_LEN must be an integer multiple of it.
- C_S_AXIS_TUSER_WIDTH, 128, stream sideband width.
- HDR_LEN, 1024, header window width in bits.
- PHV_LEN, 1579, PHV width (1024+7+24*8+5*20+256).
- META_LEN, 256, metadata field width in bits; occupies PHV low bits.

Ports:
- axis_clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  packet data; byte 0 in bits [7:0]
- s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband; [23:16] = source port, valid on first beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tready  out  1  beat accept
- phv_out  out  PHV_LEN  parsed header vector to stage 0 phv_in
- phv_out_valid  out  1  one-cycle PHV strobe to stage 0 phv_in_valid

Behaviour:
- Reset (aresetn low, async): state IDLE, beat_cnt 0, len 0, hdr window 0, s_axis_tready 0, phv_out 0, phv_out_valid 0.
- s_axis_tready is a register: 0 in reset, 1 from the first clock edge after release; never deasserts otherwise.
- Accepted beat: s_axis_tvalid & s_axis_tready.
- N = HDR_LEN/C_S_AXIS_DATA_WIDTH beats form the window.
  - Beat k (k<N) is written to window[HDR_LEN-1-k*DW -: DW], byte-swapped so packet byte 0 lands at window MSB.
  - Bytes with tkeep=0 are written as 0.
- State machine:
  - IDLE: accepted beat = first beat. Clear window, write beat 0, latch src port = tuser[23:16], len = popcount(tkeep).
    - If tlast: EMIT path (see below) and stay IDLE.
    - Else: go to HDR if N>1, otherwise go to BODY.
  - HDR: each accepted beat is written at index beat_cnt and added to len. Go to BODY after beat N-1. tlast goes to IDLE.
  - BODY: beats are not stored; len += popcount(tkeep). tlast goes to IDLE.
- len is 16 bits and saturates at 16'hFFFF (no wrap).
- EMIT: on the cycle tlast is accepted, phv_out is registered; phv_out_valid = 1 on the next cycle for exactly one cycle. Layout:
  - phv_out[PHV_LEN-1 -: HDR_LEN] = window including the current beat (packets shorter than window leave zeros).
  - phv_out[META_LEN-1:0] = {232'b0, src_port[7:0], len[15:0]}.
  - All other bits 0.
- phv_out holds its value between strobes.
- Latency: tlast accepted at cycle t → phv_out_valid at t+1.
- Back-to-back: a first beat in the cycle after tlast is accepted normally while the previous PHV strobes. Every cycle may carry a beat.
- Single-beat packet: window = that beat only; len = its popcount.
- s_axis_tvalid low: no state change (gaps mid-packet allowed).
- Reset mid-packet: everything cleared, no PHV for the partial packet. The first beat accepted after reset is treated as a packet start.

Decomposition:
- Package phv_pkg: PHV_LEN, HDR_LEN, META_LEN, META_LEN_LSB=0, META_PORT_LSB=16, LEN_W=16, state enum {IDLE,HDR,BODY}.
- Sub-module keep_popcount: tkeep in → byte count out, combinational. It is reused by the deparser.

Test Plan:
- 1-beat packet, tkeep all-ones, tuser[23:16]=8'h03, tlast → t+1: phv_out_valid 1 cycle, window top 256 bits = data (byte-swapped), rest of window 0, meta[15:0]=32, meta[23:16]=3.
- 6-beat packet, last tkeep=32'h0000_FFFF → window = beats 0..3, meta len=176; beats 4-5 absent from PHV.
- Two back-to-back 2-beat packets, no idle cycle → two strobes two cycles apart, second PHV carries its own port/len, first PHV unaffected.
- Packet with tvalid gaps of 3 cycles between beats → PHV identical to gap-free run.
- aresetn low during beat 2 of 4, then 1-beat packet → outputs 0 and tready 0 in reset; single PHV for the new packet only.
- 2100-beat all-ones packet → len saturates at 16'hFFFF.
